scanner_comm_rx: RTL and testbench
==================================

// Module: scanner_comm_rx
// PURPOSE
// Receive side of the 2-bit inter-scanner command link. Samples the peer scanner's
// transmitComm code, turns each new non-INACTIVE code into exactly one command,
// queues commands in a small FIFO and presents them to the local scanner FSM
// through a valid/accept handshake, so commands arriving in a non-listening state are held, not lost.
// PARAMETERS
// DEPTH   4  FIFO entries; power of 2, >= 2
// PTR_W   2  log2(DEPTH); pointer width
// PORTS
// clk              in   1        system clock, rising edge
// reset            in   1        asynchronous, active-low; 0 clears all state immediately
// receiveComm      in   2        raw peer code: 00 INACTIVE, 01 GO_TO_STANDBY, 10 START_SCAN, 11 START_FLUSH
// accept           in   1        local FSM consumes the head command this cycle
// clear_overflow   in   1        clears the sticky overflow flag
// cmd_valid        out  1        FIFO non-empty; head command on cmd_code
// cmd_code         out  2        head command code; 00 when cmd_valid=0
// cmd_standby      out  1        cmd_valid & cmd_code==01
// cmd_scan         out  1        cmd_valid & cmd_code==10
// cmd_flush        out  1        cmd_valid & cmd_code==11
// overflow         out  1        sticky: a command was dropped because the FIFO was full
// fill             out  PTR_W+1  entries currently queued, 0..DEPTH
// BEHAVIOUR
// - Reset (reset=0, async): sampler=00, detector=IDLE, held_code=00, pointers=0,
//   fill=0, cmd_valid=0, cmd_code=00, all decodes=0, overflow=0.
// - Input stage: receiveComm is registered once (samp) every cycle; all logic uses samp.
// - Detector FSM (states IDLE, HELD; held_code register):
//   IDLE: samp==00 -> stay; samp!=00 -> push(samp), held_code<=samp, go HELD.
//   HELD: samp==held_code -> stay, no push; samp==00 -> go IDLE;
//         samp!=00 and !=held_code -> push(samp), held_code<=samp, stay HELD.
//   A code held for N cycles yields one command; back-to-back distinct codes yield one each.
// - Latency: code on receiveComm before edge k -> samp after k -> written at edge k+1 ->
//   cmd_valid=1 after edge k+1 if FIFO was empty (2 cycles).
// - FIFO: first-word-fall-through; cmd_code/decodes combinational from head entry.
//   Pop when accept & cmd_valid; accept while cmd_valid=0 is ignored (no underflow).
//   fill = writes - reads; pointers wrap modulo DEPTH.
// - Push while full: if pop same cycle, push succeeds (fill stays DEPTH); else command
//   dropped, FIFO unchanged, overflow<=1.
// - Push and pop when fill==1: both happen; fill stays 1, new head visible next cycle.
// - overflow: set by drop, cleared by clear_overflow; drop wins if both same cycle.
// - Reset asserted mid-operation discards queued commands; no command emitted on release
//   even if receiveComm is non-INACTIVE at release? No: samp restarts at 00, so a code
//   still held at release is detected once via IDLE (2 cycles after release).
// TESTING
// 1 receiveComm=10 for 1 cycle, accept=0 -> cmd_valid=1, cmd_scan=1, fill=1 two cycles later; held.
// 2 receiveComm=01 held 6 cycles then 00 -> exactly one command queued (fill=1), code 01.
// 3 receiveComm 11,10,01 on consecutive cycles -> three entries, popped in order 11,10,01 with accept=1.
// 4 five distinct pushes (alternate 01/10), accept=0, DEPTH=4 -> fill=4, overflow=1, head still first code;
//   clear_overflow=1 -> overflow=0.
// 5 fill=4, new code arrives same cycle as accept -> fill stays 4, overflow stays 0, order preserved.
// 6 fill=3, reset low mid-cycle -> cmd_valid=0, fill=0 immediately (before next clk edge).

Source files
------------

// File: rtl/scanner_comm_rx.sv
// ---------------------------------------------------------------------------
// scanner_comm_rx
//
// Receive side of the 2-bit inter-scanner command link. The peer scanner
// drives a level code on receiveComm; this block registers it, detects each
// new non-INACTIVE code (edge-style, so a code held for many cycles produces
// only one command), and queues the resulting commands in a small
// first-word-fall-through FIFO. The local scanner FSM sees the head command
// through a valid/accept handshake. This means a command that arrives while
// the local FSM is not listening is held rather than lost.
//
// Code map: 00 INACTIVE, 01 GO_TO_STANDBY, 10 START_SCAN, 11 START_FLUSH
//
// Parameters
//   DEPTH  FIFO entries (power of 2, >= 2)
//   PTR_W  log2(DEPTH), FIFO pointer width
//
// Ports
//   clk             in   system clock, rising edge
//   reset           in   asynchronous, active-low; 0 clears all state
//   receiveComm     in   raw 2-bit peer code
//   accept          in   local FSM consumes the head command this cycle
//   clear_overflow  in   clears the sticky overflow flag
//   cmd_valid       out  FIFO non-empty; head command is on cmd_code
//   cmd_code        out  head command code, 00 when cmd_valid=0
//   cmd_standby     out  head command is GO_TO_STANDBY
//   cmd_scan        out  head command is START_SCAN
//   cmd_flush       out  head command is START_FLUSH
//   overflow        out  sticky: a command was dropped on a full FIFO
//   fill            out  number of queued entries, 0..DEPTH
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module scanner_comm_rx #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       receiveComm,
  input  logic             accept,
  input  logic             clear_overflow,
  output logic             cmd_valid,
  output logic [1:0]       cmd_code,
  output logic             cmd_standby,
  output logic             cmd_scan,
  output logic             cmd_flush,
  output logic             overflow,
  output logic [PTR_W:0]   fill
);

  localparam logic [1:0]     CODE_INACTIVE = 2'b00;
  localparam logic [1:0]     CODE_STANDBY  = 2'b01;
  localparam logic [1:0]     CODE_SCAN     = 2'b10;
  localparam logic [1:0]     CODE_FLUSH    = 2'b11;
  localparam logic [PTR_W:0] FULL_COUNT    = (PTR_W + 1)'(DEPTH);

  typedef enum logic {
    IDLE,
    HELD
  } det_state_t;

  // Input stage state
  logic [1:0]       samp;

  // Detector state
  det_state_t       det_state;
  logic [1:0]       held_code;
  logic             push;

  // FIFO state
  logic [1:0]       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             fifo_empty;
  logic             fifo_full;
  logic             pop;
  logic             do_write;
  logic             drop;

  // The peer code crosses from another scanner, so it is registered once
  // before anything looks at it. All downstream logic sees only samp.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      samp <= CODE_INACTIVE;
    end else begin
      samp <= receiveComm;
    end
  end

  // A command is produced when samp shows a non-INACTIVE code that differs
  // from the one already turned into a command. Going through INACTIVE
  // re-arms the detector so the same code can be sent again later.
  always_comb begin
    push = 1'b0;
    case (det_state)
      IDLE:    push = (samp != CODE_INACTIVE);
      HELD:    push = (samp != CODE_INACTIVE) && (samp != held_code);
      default: push = 1'b0;
    endcase
  end

  // Detector FSM: IDLE waits for a non-INACTIVE code; HELD remembers which
  // code was last reported so that a long-held level is reported once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      det_state <= IDLE;
      held_code <= CODE_INACTIVE;
    end else begin
      case (det_state)
        IDLE: begin
          if (samp != CODE_INACTIVE) begin
            held_code <= samp;
            det_state <= HELD;
          end
        end
        HELD: begin
          if (samp == CODE_INACTIVE) begin
            det_state <= IDLE;
          end else if (samp != held_code) begin
            held_code <= samp;
          end
        end
        default: begin
          det_state <= IDLE;
          held_code <= CODE_INACTIVE;
        end
      endcase
    end
  end

  // A pop frees the head slot on the same edge, so a push into a full FIFO
  // still fits when it coincides with a pop. Only an unmatched push into a
  // full FIFO is dropped.
  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == FULL_COUNT);
  assign pop        = accept && !fifo_empty;
  assign do_write   = push && (!fifo_full || pop);
  assign drop       = push && fifo_full && !pop;

  // Storage array. When full with a simultaneous push and pop, wr_ptr equals
  // rd_ptr and the outgoing head slot is reused for the new entry.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= CODE_INACTIVE;
      end
    end else if (do_write) begin
      mem[wr_ptr] <= samp;
    end
  end

  // Pointers wrap naturally at DEPTH because DEPTH is a power of two. The
  // occupancy counter is kept separately so full and empty are unambiguous.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_write) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({do_write, pop})
        2'b10:   count <= count + (PTR_W + 1)'(1);
        2'b01:   count <= count - (PTR_W + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Sticky overflow. A drop in the same cycle as a clear request wins, so
  // software never misses a loss that happened while it was acknowledging.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (clear_overflow) begin
      overflow <= 1'b0;
    end
  end

  // Head of the FIFO is presented combinationally (fall-through), forced to
  // INACTIVE when empty so the decodes can never fire on stale storage.
  assign cmd_valid   = !fifo_empty;
  assign cmd_code    = fifo_empty ? CODE_INACTIVE : mem[rd_ptr];
  assign cmd_standby = cmd_valid && (cmd_code == CODE_STANDBY);
  assign cmd_scan    = cmd_valid && (cmd_code == CODE_SCAN);
  assign cmd_flush   = cmd_valid && (cmd_code == CODE_FLUSH);
  assign fill        = count;

endmodule

// File: tb/tb_scanner_comm_rx.sv
// ---------------------------------------------------------------------------
// tb_scanner_comm_rx
//
// Directed self-checking bench for scanner_comm_rx (DEPTH=4). Inputs are
// driven 1 ns after a rising edge and outputs are observed at that same
// point, i.e. they reflect the most recent edge.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_scanner_comm_rx;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] receive_comm;
  logic       accept;
  logic       clear_ovf;
  logic       cmd_valid;
  logic [1:0] cmd_code;
  logic       cmd_standby;
  logic       cmd_scan;
  logic       cmd_flush;
  logic       overflow;
  logic [2:0] fill;

  int compared   = 0;
  int mismatched = 0;

  // 10 ns clock, rising edges at 5, 15, 25, ...
  always #5 clk = ~clk;

  scanner_comm_rx #(
    .DEPTH(4),
    .PTR_W(2)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .receiveComm    (receive_comm),
    .accept         (accept),
    .clear_overflow (clear_ovf),
    .cmd_valid      (cmd_valid),
    .cmd_code       (cmd_code),
    .cmd_standby    (cmd_standby),
    .cmd_scan       (cmd_scan),
    .cmd_flush      (cmd_flush),
    .overflow       (overflow),
    .fill           (fill)
  );

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] code, input logic acc,
                               input logic clr);
    receive_comm = code;
    accept       = acc;
    clear_ovf    = clr;
  endtask

  // Advance n rising edges and settle 1 ns past the last one.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    reset = 1'b0;
    applyStimulus(2'd0, 1'b0, 1'b0);

    // Reset state
    #3;
    checkOutput("rst_valid", 32'(cmd_valid), 0);
    checkOutput("rst_code", 32'(cmd_code), 0);
    checkOutput("rst_fill", 32'(fill), 0);
    checkOutput("rst_overflow", 32'(overflow), 0);
    checkOutput("rst_decodes", 32'({cmd_standby, cmd_scan, cmd_flush}), 0);
    #9;
    reset = 1'b1;
    tick(1);

    // Accept on an empty FIFO must not underflow
    applyStimulus(2'd0, 1'b1, 1'b0);
    tick(1);
    applyStimulus(2'd0, 1'b0, 1'b0);
    checkOutput("empty_accept_fill", 32'(fill), 0);
    checkOutput("empty_accept_valid", 32'(cmd_valid), 0);

    // Test 1: single-cycle START_SCAN, two-cycle latency, held until accepted
    applyStimulus(2'd2, 1'b0, 1'b0);
    tick(1);
    applyStimulus(2'd0, 1'b0, 1'b0);
    checkOutput("t1_not_yet_valid", 32'(cmd_valid), 0);
    tick(1);
    checkOutput("t1_valid", 32'(cmd_valid), 1);
    checkOutput("t1_scan", 32'(cmd_scan), 1);
    checkOutput("t1_standby", 32'(cmd_standby), 0);
    checkOutput("t1_code", 32'(cmd_code), 2);
    checkOutput("t1_fill", 32'(fill), 1);
    tick(3);
    checkOutput("t1_held_valid", 32'(cmd_valid), 1);
    checkOutput("t1_held_fill", 32'(fill), 1);
    applyStimulus(2'd0, 1'b1, 1'b0);
    tick(1);
    applyStimulus(2'd0, 1'b0, 1'b0);
    checkOutput("t1_pop_fill", 32'(fill), 0);
    checkOutput("t1_pop_code", 32'(cmd_code), 0);

    // Test 2: GO_TO_STANDBY held 6 cycles gives exactly one command
    applyStimulus(2'd1, 1'b0, 1'b0);
    tick(6);
    applyStimulus(2'd0, 1'b0, 1'b0);
    tick(3);
    checkOutput("t2_fill", 32'(fill), 1);
    checkOutput("t2_code", 32'(cmd_code), 1);
    checkOutput("t2_standby", 32'(cmd_standby), 1);
    applyStimulus(2'd0, 1'b1, 1'b0);
    tick(1);
    applyStimulus(2'd0, 1'b0, 1'b0);

    // Test 3: back-to-back distinct codes, popped in arrival order
    applyStimulus(2'd3, 1'b0, 1'b0);
    tick(1);
    applyStimulus(2'd2, 1'b0, 1'b0);
    tick(1);
    applyStimulus(2'd1, 1'b0, 1'b0);
    tick(1);
    applyStimulus(2'd0, 1'b0, 1'b0);
    tick(2);
    checkOutput("t3_fill", 32'(fill), 3);
    applyStimulus(2'd0, 1'b1, 1'b0);
    checkOutput("t3_head0", 32'(cmd_code), 3);
    checkOutput("t3_flush", 32'(cmd_flush), 1);
    tick(1);
    checkOutput("t3_head1", 32'(cmd_code), 2);
    tick(1);
    checkOutput("t3_head2", 32'(cmd_code), 1);
    tick(1);
    applyStimulus(2'd0, 1'b0, 1'b0);
    checkOutput("t3_drained", 32'(fill), 0);

    // Test 4: five pushes into DEPTH=4, fifth is dropped
    applyStimulus(2'd1, 1'b0, 1'b0);
    tick(1);
    applyStimulus(2'd2, 1'b0, 1'b0);
    tick(1);
    applyStimulus(2'd1, 1'b0, 1'b0);
    tick(1);
    applyStimulus(2'd2, 1'b0, 1'b0);
    tick(1);
    applyStimulus(2'd1, 1'b0, 1'b0);
    tick(1);
    applyStimulus(2'd0, 1'b0, 1'b0);
    tick(2);
    checkOutput("t4_fill", 32'(fill), 4);
    checkOutput("t4_overflow", 32'(overflow), 1);
    checkOutput("t4_head", 32'(cmd_code), 1);
    applyStimulus(2'd0, 1'b0, 1'b1);
    tick(1);
    applyStimulus(2'd0, 1'b0, 1'b0);
    checkOutput("t4_cleared", 32'(overflow), 0);

    // Drop and clear on the same edge: drop wins
    applyStimulus(2'd3, 1'b0, 1'b0);
    tick(1);
    applyStimulus(2'd3, 1'b0, 1'b1);
    tick(1);
    applyStimulus(2'd0, 1'b0, 1'b0);
    checkOutput("t4_drop_wins", 32'(overflow), 1);
    tick(1);
    checkOutput("t4_drop_fill", 32'(fill), 4);
    applyStimulus(2'd0, 1'b0, 1'b1);
    tick(1);
    applyStimulus(2'd0, 1'b0, 1'b0);
    checkOutput("t4_cleared2", 32'(overflow), 0);

    // Test 5: full FIFO, push coincides with pop; queue 1,2,1,2 -> 2,1,2,3
    applyStimulus(2'd3, 1'b0, 1'b0);
    tick(1);
    applyStimulus(2'd3, 1'b1, 1'b0);
    tick(1);
    applyStimulus(2'd0, 1'b0, 1'b0);
    checkOutput("t5_fill", 32'(fill), 4);
    checkOutput("t5_overflow", 32'(overflow), 0);
    applyStimulus(2'd0, 1'b1, 1'b0);
    checkOutput("t5_head0", 32'(cmd_code), 2);
    tick(1);
    checkOutput("t5_head1", 32'(cmd_code), 1);
    tick(1);
    checkOutput("t5_head2", 32'(cmd_code), 2);
    tick(1);
    checkOutput("t5_head3", 32'(cmd_code), 3);
    tick(1);
    applyStimulus(2'd0, 1'b0, 1'b0);
    checkOutput("t5_drained", 32'(fill), 0);

    // Test 6: asynchronous reset with three entries queued
    applyStimulus(2'd1, 1'b0, 1'b0);
    tick(1);
    applyStimulus(2'd2, 1'b0, 1'b0);
    tick(1);
    applyStimulus(2'd3, 1'b0, 1'b0);
    tick(1);
    applyStimulus(2'd0, 1'b0, 1'b0);
    tick(2);
    checkOutput("t6_fill_before", 32'(fill), 3);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("t6_async_valid", 32'(cmd_valid), 0);
    checkOutput("t6_async_fill", 32'(fill), 0);

    // Code held through reset release is reported once, two edges later
    applyStimulus(2'd2, 1'b0, 1'b0);
    #2;
    reset = 1'b1;
    tick(1);
    checkOutput("t6_release_lat", 32'(cmd_valid), 0);
    tick(1);
    checkOutput("t6_release_valid", 32'(cmd_valid), 1);
    checkOutput("t6_release_code", 32'(cmd_code), 2);
    tick(3);
    checkOutput("t6_release_once", 32'(fill), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
